// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: transfer-descriptor layout, arbiter owner codes,
// arbiter state enum and the descriptor pack/unpack helpers used by the
// CSR command engine, xip_engine and qspi_fsm_arbiter.
package qspi_pkg;

  localparam int unsigned DESC_W = 128;

  // Descriptor field offsets (LSB) and widths
  localparam int unsigned CPHA_LSB       = 0;   localparam int unsigned CPHA_W       = 1;
  localparam int unsigned CPOL_LSB       = 1;   localparam int unsigned CPOL_W       = 1;
  localparam int unsigned CLK_DIV_LSB    = 2;   localparam int unsigned CLK_DIV_W    = 8;
  localparam int unsigned LEN_LSB        = 10;  localparam int unsigned LEN_W        = 16;
  localparam int unsigned ADDR_LSB       = 26;  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned MODE_BITS_LSB  = 58;  localparam int unsigned MODE_BITS_W  = 8;
  localparam int unsigned OPCODE_LSB     = 66;  localparam int unsigned OPCODE_W     = 8;
  localparam int unsigned CONT_LSB       = 74;  localparam int unsigned CONT_W       = 1;
  localparam int unsigned CS_AUTO_LSB    = 75;  localparam int unsigned CS_AUTO_W    = 1;
  localparam int unsigned QUAD_LSB       = 76;  localparam int unsigned QUAD_W       = 1;
  localparam int unsigned DIR_LSB        = 77;  localparam int unsigned DIR_W        = 1;
  localparam int unsigned DUMMY_LSB      = 78;  localparam int unsigned DUMMY_W      = 5;
  localparam int unsigned MODE_LSB       = 83;  localparam int unsigned MODE_W       = 1;
  localparam int unsigned ADDR_BYTES_LSB = 84;  localparam int unsigned ADDR_BYTES_W = 3;
  localparam int unsigned LANES_LSB      = 87;  localparam int unsigned LANES_W      = 2;
  localparam int unsigned RSVD_LSB       = 89;  localparam int unsigned RSVD_W       = 39;

  // Declared MSB first so each field lands on the offsets above
  typedef struct packed {
    logic [RSVD_W-1:0]       rsvd;
    logic [LANES_W-1:0]      lanes;
    logic [ADDR_BYTES_W-1:0] addr_bytes;
    logic                    mode;
    logic [DUMMY_W-1:0]      dummy;
    logic                    dir;
    logic                    quad;
    logic                    cs_auto;
    logic                    cont;
    logic [OPCODE_W-1:0]     opcode;
    logic [MODE_BITS_W-1:0]  mode_bits;
    logic [ADDR_W-1:0]       addr;
    logic [LEN_W-1:0]        len;
    logic [CLK_DIV_W-1:0]    clk_div;
    logic                    cpol;
    logic                    cpha;
  } desc_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CMD  = 2'b01;
  localparam logic [1:0] OWN_XIP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } arb_state_t;

  function automatic logic [DESC_W-1:0] desc_pack(input desc_t d);
    return DESC_W'(d);
  endfunction

  function automatic desc_t desc_unpack(input logic [DESC_W-1:0] v);
    return desc_t'(v);
  endfunction

endpackage

// File: rtl/qspi_fsm_arbiter_if.sv
// Bus bundle between the two requesters (cmd, xip), the arbiter and qspi_fsm.
// slave modport: arbiter view. master modport: requester/FSM side view.
interface qspi_fsm_arbiter_if;
  import qspi_pkg::*;

  logic              cmd_start_i;
  logic [DESC_W-1:0] cmd_desc_i;
  logic [31:0]       cmd_tx_data_i;
  logic              cmd_tx_empty_i;
  logic              cmd_tx_ren_o;
  logic              cmd_rx_wen_o;
  logic              cmd_done_o;
  logic              cmd_busy_o;

  logic              xip_start_i;
  logic [DESC_W-1:0] xip_desc_i;
  logic [31:0]       xip_tx_data_i;
  logic              xip_tx_empty_i;
  logic              xip_tx_ren_o;
  logic              xip_rx_wen_o;
  logic              xip_done_o;

  logic              fsm_start_o;
  logic [DESC_W-1:0] fsm_desc_o;
  logic [31:0]       fsm_tx_data_o;
  logic              fsm_tx_empty_o;
  logic              fsm_done_i;
  logic              fsm_tx_ren_i;
  logic              fsm_rx_wen_i;

  logic [1:0]        owner_o;
  logic [1:0]        req_ovf_o;

  modport slave (
    input  cmd_start_i, cmd_desc_i, cmd_tx_data_i, cmd_tx_empty_i,
    input  xip_start_i, xip_desc_i, xip_tx_data_i, xip_tx_empty_i,
    input  fsm_done_i, fsm_tx_ren_i, fsm_rx_wen_i,
    output cmd_tx_ren_o, cmd_rx_wen_o, cmd_done_o, cmd_busy_o,
    output xip_tx_ren_o, xip_rx_wen_o, xip_done_o,
    output fsm_start_o, fsm_desc_o, fsm_tx_data_o, fsm_tx_empty_o,
    output owner_o, req_ovf_o
  );

  modport master (
    output cmd_start_i, cmd_desc_i, cmd_tx_data_i, cmd_tx_empty_i,
    output xip_start_i, xip_desc_i, xip_tx_data_i, xip_tx_empty_i,
    output fsm_done_i, fsm_tx_ren_i, fsm_rx_wen_i,
    input  cmd_tx_ren_o, cmd_rx_wen_o, cmd_done_o, cmd_busy_o,
    input  xip_tx_ren_o, xip_rx_wen_o, xip_done_o,
    input  fsm_start_o, fsm_desc_o, fsm_tx_data_o, fsm_tx_empty_o,
    input  owner_o, req_ovf_o
  );

endinterface

// File: rtl/qspi_arb_req_slot.sv
// One requester slot: pending flag, captured descriptor, sticky overflow.
// Ports: clk, reset (sync, active-high); start/desc_in from the requester;
//   active = requester currently owns the FSM and is not finishing this cycle;
//   launch = arbiter is launching this requester (clears pending);
//   pending, desc, ovf outputs (all registered).
module qspi_arb_req_slot
  import qspi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DESC_W-1:0] desc_in,
  input  logic              active,
  input  logic              launch,
  output logic              pending,
  output logic [DESC_W-1:0] desc,
  output logic              ovf
);

  // A start while pending or owning is dropped and flagged; launch implies
  // pending, so capture and clear never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
      desc    <= '0;
      ovf     <= 1'b0;
    end else begin
      if (launch) pending <= 1'b0;
      if (start) begin
        if (pending || active) begin
          ovf <= 1'b1;
        end else begin
          pending <= 1'b1;
          desc    <= desc_in;
        end
      end
    end
  end

endmodule

// File: rtl/qspi_fsm_arbiter.sv
// Arbitrates the single qspi_fsm between the CSR command engine (cmd) and the
// xip_engine (xip). Latches starts/descriptors, grants one owner, issues one
// fsm start, and steers TX reads, RX writes and done to the owner only.
// Ports: clk, reset (sync, active-high), bus (qspi_fsm_arbiter_if.slave).
// Build option: QSPI_ARB_RR_EN selects round-robin on ties; otherwise cmd
// always wins ties.
module qspi_fsm_arbiter
  import qspi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  qspi_fsm_arbiter_if.slave     bus
);

  arb_state_t        state;
  logic [1:0]        owner;
  logic              start_q;
  logic [DESC_W-1:0] desc_q;

  logic              cmd_pend, xip_pend;
  logic [DESC_W-1:0] cmd_desc, xip_desc;
  logic              cmd_ovf, xip_ovf;

  logic              cmd_own, xip_own, done_now;
  logic [1:0]        tie_win, pick;

  assign cmd_own  = (owner == OWN_CMD);
  assign xip_own  = (owner == OWN_XIP);
  assign done_now = (state == ST_RUN) && bus.fsm_done_i;

  // Owner stops counting as busy in its done cycle so a new start is taken
  qspi_arb_req_slot u_cmd_slot (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.cmd_start_i),
    .desc_in (bus.cmd_desc_i),
    .active  (cmd_own && !done_now),
    .launch  ((state == ST_LAUNCH) && cmd_own),
    .pending (cmd_pend),
    .desc    (cmd_desc),
    .ovf     (cmd_ovf)
  );

  qspi_arb_req_slot u_xip_slot (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.xip_start_i),
    .desc_in (bus.xip_desc_i),
    .active  (xip_own && !done_now),
    .launch  ((state == ST_LAUNCH) && xip_own),
    .pending (xip_pend),
    .desc    (xip_desc),
    .ovf     (xip_ovf)
  );

`ifdef QSPI_ARB_RR_EN
  // Winner of the most recent tie; the other side wins the next tie
  logic [1:0] last_tie;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_tie <= OWN_XIP;
    end else if ((state == ST_IDLE) && cmd_pend && xip_pend) begin
      last_tie <= tie_win;
    end
  end

  assign tie_win = (last_tie == OWN_XIP) ? OWN_CMD : OWN_XIP;
`else
  assign tie_win = OWN_CMD;
`endif

  assign pick = (cmd_pend && xip_pend) ? tie_win :
                cmd_pend               ? OWN_CMD : OWN_XIP;

  // Grant FSM with registered start pulse, descriptor and owner
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= OWN_NONE;
      start_q <= 1'b0;
      desc_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_pend || xip_pend) begin
            owner   <= pick;
            start_q <= 1'b1;
            desc_q  <= (pick == OWN_CMD) ? cmd_desc : xip_desc;
            state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          start_q <= 1'b0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.fsm_done_i) begin
            owner <= OWN_NONE;
            state <= ST_IDLE;
          end
        end
        default: begin
          owner   <= OWN_NONE;
          start_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fsm_start_o    = start_q;
  assign bus.fsm_desc_o     = desc_q;
  assign bus.owner_o        = owner;
  assign bus.req_ovf_o      = {xip_ovf, cmd_ovf};
  assign bus.cmd_busy_o     = cmd_pend || cmd_own;

  // Zero-latency steering keyed on owner only
  assign bus.fsm_tx_data_o  = cmd_own ? bus.cmd_tx_data_i :
                              xip_own ? bus.xip_tx_data_i : 32'd0;
  assign bus.fsm_tx_empty_o = cmd_own ? bus.cmd_tx_empty_i :
                              xip_own ? bus.xip_tx_empty_i : 1'b1;
  assign bus.cmd_tx_ren_o   = cmd_own && bus.fsm_tx_ren_i;
  assign bus.xip_tx_ren_o   = xip_own && bus.fsm_tx_ren_i;
  assign bus.cmd_rx_wen_o   = cmd_own && bus.fsm_rx_wen_i;
  assign bus.xip_rx_wen_o   = xip_own && bus.fsm_rx_wen_i;
  assign bus.cmd_done_o     = cmd_own && done_now;
  assign bus.xip_done_o     = xip_own && done_now;

endmodule

// File: tb/tb_qspi_fsm_arbiter.sv
// Directed self-checking bench for qspi_fsm_arbiter (either tie policy build).
module tb_qspi_fsm_arbiter;
  import qspi_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  qspi_fsm_arbiter_if bus();

  qspi_fsm_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n0 = 0;

  // Cycles in which the FSM start strobe was high
  always @(posedge clk) if (bus.fsm_start_o === 1'b1) n_start++;

`ifdef QSPI_ARB_RR_EN
  localparam logic [1:0] TIE2_FIRST  = OWN_XIP;
  localparam logic [1:0] TIE2_SECOND = OWN_CMD;
`else
  localparam logic [1:0] TIE2_FIRST  = OWN_CMD;
  localparam logic [1:0] TIE2_SECOND = OWN_XIP;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic finish_xfer();
    bus.fsm_done_i = 1'b1;
    tick();
    bus.fsm_done_i = 1'b0;
  endtask

  desc_t d;
  logic [DESC_W-1:0] d_cmd, d_cmd2, d_xip;

  initial begin
    bus.cmd_start_i = 1'b0; bus.cmd_desc_i = '0;
    bus.cmd_tx_data_i = 32'hC0DE_0001; bus.cmd_tx_empty_i = 1'b0;
    bus.xip_start_i = 1'b0; bus.xip_desc_i = '0;
    bus.xip_tx_data_i = 32'h5151_0002; bus.xip_tx_empty_i = 1'b1;
    bus.fsm_done_i = 1'b0; bus.fsm_tx_ren_i = 1'b0; bus.fsm_rx_wen_i = 1'b0;

    d = '0; d.opcode = 8'h9F; d.len = 16'd4; d.lanes = 2'd0;
    d_cmd = desc_pack(d);
    d = '0; d.opcode = 8'h06; d.cs_auto = 1'b1;
    d_cmd2 = desc_pack(d);
    d = '0; d.opcode = 8'hEB; d.quad = 1'b1; d.addr = 32'h0; d.len = 16'd4; d.dummy = 5'd6;
    d_xip = desc_pack(d);

    // Reset state
    tick(); tick();
    chk("rst_owner", bus.owner_o, OWN_NONE);
    chk("rst_ovf", bus.req_ovf_o, 2'b00);
    chk("rst_desc", bus.fsm_desc_o, '0);
    chk("rst_busy", bus.cmd_busy_o, 1'b0);
    chk("rst_start", bus.fsm_start_o, 1'b0);
    chk("rst_empty", bus.fsm_tx_empty_o, 1'b1);
    chk("rst_data", bus.fsm_tx_data_o, 32'd0);
    reset = 1'b0;
    tick();

    // Lone cmd transfer
    n0 = n_start;
    bus.cmd_desc_i = d_cmd; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    chk("s1_busy_pend", bus.cmd_busy_o, 1'b1);
    chk("s1_no_start_yet", bus.fsm_start_o, 1'b0);
    tick();
    chk("s1_launch", bus.fsm_start_o, 1'b1);
    chk("s1_owner", bus.owner_o, OWN_CMD);
    d = desc_unpack(bus.fsm_desc_o);
    chk("s1_opcode", d.opcode, 8'h9F);
    chk("s1_len", d.len, 16'd4);
    chk("s1_busy_launch", bus.cmd_busy_o, 1'b1);
    tick();
    chk("s1_start_1cyc", bus.fsm_start_o, 1'b0);
    chk("s1_desc_hold", bus.fsm_desc_o, d_cmd);
    bus.fsm_tx_ren_i = 1'b1; bus.fsm_rx_wen_i = 1'b1;
    #1;
    chk("s1_cmd_ren", bus.cmd_tx_ren_o, 1'b1);
    chk("s1_xip_ren", bus.xip_tx_ren_o, 1'b0);
    chk("s1_cmd_wen", bus.cmd_rx_wen_o, 1'b1);
    chk("s1_xip_wen", bus.xip_rx_wen_o, 1'b0);
    chk("s1_tx_data", bus.fsm_tx_data_o, 32'hC0DE_0001);
    chk("s1_tx_empty", bus.fsm_tx_empty_o, 1'b0);
    bus.fsm_tx_ren_i = 1'b0; bus.fsm_rx_wen_i = 1'b0;
    bus.fsm_done_i = 1'b1;
    #1;
    chk("s1_cmd_done", bus.cmd_done_o, 1'b1);
    chk("s1_xip_done", bus.xip_done_o, 1'b0);
    tick();
    bus.fsm_done_i = 1'b0;
    chk("s1_owner_idle", bus.owner_o, OWN_NONE);
    chk("s1_busy_end", bus.cmd_busy_o, 1'b0);
    chk("s1_idle_empty", bus.fsm_tx_empty_o, 1'b1);
    chk("s1_one_start", 32'(n_start - n0), 32'd1);

    // Lone xip transfer
    bus.xip_desc_i = d_xip; bus.xip_start_i = 1'b1;
    tick();
    bus.xip_start_i = 1'b0;
    chk("s2_cmd_not_busy", bus.cmd_busy_o, 1'b0);
    tick();
    chk("s2_launch", bus.fsm_start_o, 1'b1);
    chk("s2_owner", bus.owner_o, OWN_XIP);
    chk("s2_desc", bus.fsm_desc_o, d_xip);
    tick();
    bus.fsm_rx_wen_i = 1'b1;
    #1;
    chk("s2_xip_wen", bus.xip_rx_wen_o, 1'b1);
    chk("s2_cmd_wen", bus.cmd_rx_wen_o, 1'b0);
    chk("s2_tx_data", bus.fsm_tx_data_o, 32'h5151_0002);
    chk("s2_tx_empty", bus.fsm_tx_empty_o, 1'b1);
    bus.fsm_rx_wen_i = 1'b0;
    bus.fsm_done_i = 1'b1;
    #1;
    chk("s2_xip_done", bus.xip_done_o, 1'b1);
    chk("s2_cmd_done", bus.cmd_done_o, 1'b0);
    tick();
    bus.fsm_done_i = 1'b0;

    // First tie: cmd wins in both builds
    bus.cmd_desc_i = d_cmd; bus.xip_desc_i = d_xip;
    bus.cmd_start_i = 1'b1; bus.xip_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0; bus.xip_start_i = 1'b0;
    tick();
    chk("s3_tie1_owner", bus.owner_o, OWN_CMD);
    chk("s3_tie1_desc", bus.fsm_desc_o, d_cmd);
    tick();
    finish_xfer();
    tick();
    chk("s3_tie1_next", bus.owner_o, OWN_XIP);
    chk("s3_tie1_next_start", bus.fsm_start_o, 1'b1);
    tick();
    finish_xfer();

    // Second tie: policy dependent
    bus.cmd_start_i = 1'b1; bus.xip_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0; bus.xip_start_i = 1'b0;
    tick();
    chk("s3_tie2_owner", bus.owner_o, TIE2_FIRST);
    tick();
    finish_xfer();
    tick();
    chk("s3_tie2_next", bus.owner_o, TIE2_SECOND);
    tick();
    finish_xfer();

    // Owner restarts in its own done cycle: accepted, no overflow
    bus.cmd_desc_i = d_cmd; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    tick(); tick();
    bus.fsm_done_i = 1'b1; bus.cmd_desc_i = d_cmd2; bus.cmd_start_i = 1'b1;
    tick();
    bus.fsm_done_i = 1'b0; bus.cmd_start_i = 1'b0;
    chk("s6_owner_idle", bus.owner_o, OWN_NONE);
    chk("s6_busy_pend", bus.cmd_busy_o, 1'b1);
    chk("s6_no_ovf", bus.req_ovf_o, 2'b00);
    tick();
    chk("s6_relaunch", bus.fsm_start_o, 1'b1);
    d = desc_unpack(bus.fsm_desc_o);
    chk("s6_opcode", d.opcode, 8'h06);
    tick();
    finish_xfer();

    // Xip start in the done cycle of a cmd transfer: launch 2 cycles later
    bus.cmd_desc_i = d_cmd; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    tick(); tick();
    bus.fsm_done_i = 1'b1; bus.xip_start_i = 1'b1;
    #1;
    chk("s5_cmd_done", bus.cmd_done_o, 1'b1);
    tick();
    bus.fsm_done_i = 1'b0; bus.xip_start_i = 1'b0;
    chk("s5_gap_start", bus.fsm_start_o, 1'b0);
    tick();
    chk("s5_xip_start", bus.fsm_start_o, 1'b1);
    chk("s5_xip_owner", bus.owner_o, OWN_XIP);
    tick();
    finish_xfer();

    // Cmd start while cmd running: dropped, sticky overflow
    n0 = n_start;
    bus.cmd_desc_i = d_cmd; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    tick(); tick();
    bus.cmd_desc_i = d_cmd2; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    chk("s4_ovf_set", bus.req_ovf_o, 2'b01);
    chk("s4_desc_kept", bus.fsm_desc_o, d_cmd);
    finish_xfer();
    tick(); tick(); tick();
    chk("s4_ovf_sticky", bus.req_ovf_o, 2'b01);
    chk("s4_owner_idle", bus.owner_o, OWN_NONE);
    chk("s4_one_start", 32'(n_start - n0), 32'd1);
    chk("s4_busy_end", bus.cmd_busy_o, 1'b0);

    // Reset mid-RUN, then a fresh start
    bus.cmd_desc_i = d_cmd; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    tick(); tick();
    chk("s7_running", bus.owner_o, OWN_CMD);
    bus.fsm_tx_ren_i = 1'b1; reset = 1'b1;
    tick();
    chk("s7_owner", bus.owner_o, OWN_NONE);
    chk("s7_ren", bus.cmd_tx_ren_o, 1'b0);
    chk("s7_done", bus.cmd_done_o, 1'b0);
    chk("s7_ovf", bus.req_ovf_o, 2'b00);
    chk("s7_desc", bus.fsm_desc_o, '0);
    chk("s7_busy", bus.cmd_busy_o, 1'b0);
    chk("s7_start", bus.fsm_start_o, 1'b0);
    reset = 1'b0; bus.fsm_tx_ren_i = 1'b0;
    tick();
    chk("s7_stay_idle", bus.fsm_start_o, 1'b0);
    bus.cmd_desc_i = d_cmd2; bus.cmd_start_i = 1'b1;
    tick();
    bus.cmd_start_i = 1'b0;
    tick();
    chk("s7_relaunch", bus.fsm_start_o, 1'b1);
    d = desc_unpack(bus.fsm_desc_o);
    chk("s7_opcode", d.opcode, 8'h06);
    tick();
    finish_xfer();
    chk("s7_owner_end", bus.owner_o, OWN_NONE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
